// File: rtl/stoch_pkg.sv
// ----------------------------------------------------------------------------
// stoch_pkg
// Shared definitions for the stochastic-computing stream blocks: the table of
// maximal-length Fibonacci LFSR tap masks (indexed by register width), the
// encoder state type, and the helper that turns a signed value into the
// unsigned comparison threshold of a bipolar stream.
// No ports (package).
// ----------------------------------------------------------------------------
package stoch_pkg;

    // Encoder control states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enc_state_t;

    // Tap masks for a left-shifting Fibonacci LFSR: bit k set means stage k+1
    // of the polynomial feeds the XOR. Entries 0 and 1 are placeholders.
    localparam logic [31:0] LFSR_TAPS [17] = '{
        32'h0000_0000,  // 0  (unused)
        32'h0000_0000,  // 1  (unused)
        32'h0000_0003,  // 2  : x^2+x+1
        32'h0000_0006,  // 3  : x^3+x^2+1
        32'h0000_000C,  // 4  : x^4+x^3+1
        32'h0000_0014,  // 5  : x^5+x^3+1
        32'h0000_0030,  // 6  : x^6+x^5+1
        32'h0000_0060,  // 7  : x^7+x^6+1
        32'h0000_00B8,  // 8  : x^8+x^6+x^5+x^4+1
        32'h0000_0110,  // 9  : x^9+x^5+1
        32'h0000_0240,  // 10 : x^10+x^7+1
        32'h0000_0500,  // 11 : x^11+x^9+1
        32'h0000_0829,  // 12 : x^12+x^6+x^4+x+1
        32'h0000_100D,  // 13 : x^13+x^4+x^3+x+1
        32'h0000_2015,  // 14 : x^14+x^5+x^3+x+1
        32'h0000_6000,  // 15 : x^15+x^14+1
        32'h0000_D008   // 16 : x^16+x^15+x^13+x^4+1
    };

    // Offset-binary threshold of a w-bit two's-complement value:
    // value + 2^(w-1) kept to w bits, i.e. the sign bit inverted.
    function automatic logic [31:0] stoch_threshold(input logic [31:0] value,
                                                    input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (value + (32'd1 << (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// ----------------------------------------------------------------------------
// stoch_lfsr
// Free-running maximal-length Fibonacci LFSR used as the random source for
// stochastic stream generators. Advances every clock it is not reset or
// loaded; a load replaces the state with LD_VAL.
// Ports:
//   CLK     in   clock, posedge
//   INIT_N  in   synchronous active-low reset, state <= SEED
//   LD      in   load request (takes priority over shifting)
//   LD_VAL  in   RW-bit value to load
//   Q       out  RW-bit current LFSR state
// ----------------------------------------------------------------------------
module stoch_lfsr
    import stoch_pkg::*;
#(
    parameter int               RW   = 8,
    parameter logic [RW-1:0]    SEED = RW'(8'hA5)
) (
    input  logic          CLK,
    input  logic          INIT_N,
    input  logic          LD,
    input  logic [RW-1:0] LD_VAL,
    output logic [RW-1:0] Q
);

    localparam logic [31:0]   TAPS_FULL = LFSR_TAPS[RW];
    localparam logic [RW-1:0] TAPS      = TAPS_FULL[RW-1:0];

    logic feedback;

    assign feedback = ^(Q & TAPS);

    always_ff @(posedge CLK) begin
        if (!INIT_N) begin
            Q <= SEED;
        end else if (LD) begin
            Q <= LD_VAL;
        end else begin
            Q <= {Q[RW-2:0], feedback};
        end
    end

endmodule

// File: rtl/stoch_bin_encoder.sv
// ----------------------------------------------------------------------------
// stoch_bin_encoder
// Binary-to-stochastic encoder. A signed W-bit VALUE is turned into a bipolar
// stochastic bitstream of LEN bits with P(1) = (VALUE + 2^(W-1)) / 2^W by
// comparing the top W bits of a free-running LFSR against the offset-binary
// threshold of VALUE.
// Optional feature macro: STOCH_ENC_SEED_EN adds SEED_IN; a nonzero SEED_IN on
// an accepted LOAD reseeds the LFSR so the stream is repeatable.
// Ports:
//   CLK      in   clock, posedge
//   INIT_N   in   synchronous active-low reset
//   LOAD     in   start request, accepted only while READY=1
//   VALUE    in   W-bit signed value, captured on accepted LOAD
//   LEN      in   LW-bit stream length, captured on accepted LOAD (0 ignored)
//   READY    out  idle, a LOAD will be accepted
//   BitOUT   out  registered stream bit, meaningful when VALID=1
//   VALID    out  BitOUT carries a stream bit this cycle
//   DONE     out  pulse coincident with the last valid bit
//   SEED_IN  in   (STOCH_ENC_SEED_EN only) RW-bit LFSR reseed value
// ----------------------------------------------------------------------------
module stoch_bin_encoder
    import stoch_pkg::*;
#(
    parameter int            W    = 4,
    parameter int            RW   = 8,
    parameter int            LW   = 16,
    parameter logic [RW-1:0] SEED = RW'(8'hA5)
) (
    input  logic          CLK,
    input  logic          INIT_N,
    input  logic          LOAD,
    input  logic [W-1:0]  VALUE,
    input  logic [LW-1:0] LEN,
    output logic          READY,
    output logic          BitOUT,
    output logic          VALID,
    output logic          DONE
`ifdef STOCH_ENC_SEED_EN
    ,
    input  logic [RW-1:0] SEED_IN
`endif
);

    enc_state_t    state;
    logic [W-1:0]  value_q;
    logic [LW-1:0] count;
    logic [W-1:0]  thr;
    logic [RW-1:0] thr_scaled;
    logic [RW-1:0] lfsr_q;
    logic          accept;
    logic          lfsr_ld;
    logic [RW-1:0] lfsr_ld_val;

    // READY is low in the DONE cycle, so gating on it also rejects a LOAD
    // that arrives alongside the last bit.
    assign accept = READY && LOAD && (LEN != '0);

`ifdef STOCH_ENC_SEED_EN
    assign lfsr_ld     = accept && (SEED_IN != '0);
    assign lfsr_ld_val = SEED_IN;
`else
    assign lfsr_ld     = 1'b0;
    assign lfsr_ld_val = '0;
`endif

    stoch_lfsr #(
        .RW   (RW),
        .SEED (SEED)
    ) u_lfsr (
        .CLK    (CLK),
        .INIT_N (INIT_N),
        .LD     (lfsr_ld),
        .LD_VAL (lfsr_ld_val),
        .Q      (lfsr_q)
    );

    // Comparing the full LFSR word against the threshold shifted into the top
    // W bits is equivalent to comparing only the top W bits, because the
    // lower bits can never carry the word across a threshold step.
    assign thr        = W'(stoch_threshold(32'(value_q), W));
    assign thr_scaled = RW'(thr) << (RW - W);

    always_ff @(posedge CLK) begin
        if (!INIT_N) begin
            state   <= IDLE;
            READY   <= 1'b1;
            BitOUT  <= 1'b0;
            VALID   <= 1'b0;
            DONE    <= 1'b0;
            value_q <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    VALID  <= 1'b0;
                    DONE   <= 1'b0;
                    BitOUT <= 1'b0;
                    if (accept) begin
                        value_q <= VALUE;
                        count   <= LEN;
                        state   <= RUN;
                        READY   <= 1'b0;
                    end else begin
                        READY   <= 1'b1;
                    end
                end
                RUN: begin
                    BitOUT <= (lfsr_q < thr_scaled);
                    VALID  <= 1'b1;
                    count  <= count - 1'b1;
                    // READY stays low through the DONE cycle and rises in IDLE.
                    if (count == LW'(1)) begin
                        DONE  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    READY <= 1'b1;
                    VALID <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stoch_bin_encoder.sv
// ----------------------------------------------------------------------------
// tb_stoch_bin_encoder
// Self-checking bench for stoch_bin_encoder. Stream properties are predicted
// from the encoding rule: a full 255-bit stream visits every nonzero 8-bit
// LFSR state once, so its ones count is the number of such states whose top
// 4 bits fall below the threshold.
// ----------------------------------------------------------------------------
module tb_stoch_bin_encoder;

    logic               clk;
    logic               init_n;
    logic               load;
    logic signed [3:0]  value;
    logic [15:0]        len;
    logic               ready;
    logic               bit_out;
    logic               valid;
    logic               done;
`ifdef STOCH_ENC_SEED_EN
    logic [7:0]         seed_in;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit bit_log[$];

    stoch_bin_encoder dut (
        .CLK    (clk),
        .INIT_N (init_n),
        .LOAD   (load),
        .VALUE  (value),
        .LEN    (len),
        .READY  (ready),
        .BitOUT (bit_out),
        .VALID  (valid),
        .DONE   (done)
`ifdef STOCH_ENC_SEED_EN
        ,
        .SEED_IN (seed_in)
`endif
    );

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the design never finishes a stream.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: ones in a full-period stream = count of nonzero 8-bit states
    // whose top 4 bits are below the offset-binary threshold value+8.
    function automatic int modelFullPeriodOnes(input int v);
        int t;
        int n;
        t = v + 8;
        n = 0;
        for (int s = 1; s < 256; s++) begin
            if ((s >> 4) < t) n++;
        end
        return n;
    endfunction

    // Runs one stream of n bits at value v, with random LOAD noise during the
    // stream and a LOAD in the DONE cycle, checking framing and counts.
    task automatic applyStimulus(input logic signed [3:0] v, input int n,
                                 output int ones);
        int  nvalid;
        int  gaps;
        int  done_pos;
        bit  got_done;
        ones     = 0;
        nvalid   = 0;
        gaps     = 0;
        done_pos = 0;
        got_done = 1'b0;
        bit_log.delete();
        checkOutput("ready_idle", 32'(ready), 1);
        load  = 1'b1;
        value = v;
        len   = 16'(n);
        @(posedge clk); #1;
        load = 1'b0;
        checkOutput("ready_low", 32'(ready), 0);
        checkOutput("valid_pre", 32'(valid), 0);
        for (int c = 0; c < n + 4; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                nvalid++;
                ones += int'(bit_out);
                bit_log.push_back(bit_out);
            end else begin
                gaps++;
            end
            if (done) begin
                done_pos = nvalid;
                got_done = 1'b1;
                load  = 1'b1;
                value = 4'($urandom);
                len   = 16'($urandom_range(1, 300));
                break;
            end
            load  = 1'($urandom_range(0, 1));
            value = 4'($urandom);
            len   = 16'($urandom_range(1, 300));
        end
        checkOutput("done_seen", 32'(got_done), 1);
        checkOutput("bit_count", 32'(nvalid), 32'(n));
        checkOutput("valid_gaps", 32'(gaps), 0);
        checkOutput("done_pos", 32'(done_pos), 32'(n));
        @(posedge clk); #1;
        load = 1'b0;
        checkOutput("post_ready", 32'(ready), 1);
        checkOutput("post_valid", 32'(valid), 0);
        checkOutput("post_done", 32'(done), 0);
        if (v == -4'sd8) checkOutput("ones_min", 32'(ones), 0);
        if (n == 255) checkOutput("ones_period", 32'(ones), 32'(modelFullPeriodOnes(int'(v))));
    endtask

    initial begin
        int ones;
        int nvalid;
        logic signed [3:0] rv;
`ifdef STOCH_ENC_SEED_EN
        bit first_log[$];
        seed_in = 8'h00;
`endif
        init_n = 1'b0;
        load   = 1'b0;
        value  = '0;
        len    = '0;

        // Reset state held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", 32'(ready), 1);
        checkOutput("rst_valid", 32'(valid), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_bit", 32'(bit_out), 0);
        checkOutput("rst_lfsr", 32'(dut.u_lfsr.Q), 32'h A5);
        init_n = 1'b1;
        @(posedge clk); #1;

        // Minimum value: all zeros.
        applyStimulus(-4'sd8, 16, ones);

        // Full-period streams at the midpoint and the maximum.
        applyStimulus(4'sd0, 255, ones);
        applyStimulus(4'sd7, 255, ones);

        // LOAD with LEN=0 in IDLE is ignored.
        load  = 1'b1;
        value = 4'sd3;
        len   = 16'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            load = 1'b0;
            checkOutput("len0_valid", 32'(valid), 0);
            checkOutput("len0_ready", 32'(ready), 1);
        end

        // Reset at bit 5 of a 20-bit stream aborts it without DONE.
        load  = 1'b1;
        value = 4'sd2;
        len   = 16'd20;
        @(posedge clk); #1;
        load   = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 10 && nvalid < 5; c++) begin
            @(posedge clk); #1;
            if (valid) nvalid++;
        end
        checkOutput("abort_reach5", 32'(nvalid), 5);
        init_n = 1'b0;
        @(posedge clk); #1;
        init_n = 1'b1;
        checkOutput("abort_valid", 32'(valid), 0);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_ready", 32'(ready), 1);
        @(posedge clk); #1;

        // Round trip through an up/down counter: sign of (ones - zeros).
        applyStimulus(4'sd5, 255, ones);
        checkOutput("rt_sign_pos", 32'((2 * ones - 255) < 0),
                    32'((2 * modelFullPeriodOnes(5) - 255) < 0));
        applyStimulus(-4'sd5, 255, ones);
        checkOutput("rt_sign_neg", 32'((2 * ones - 255) < 0),
                    32'((2 * modelFullPeriodOnes(-5) - 255) < 0));

        // Randomized values and lengths.
        for (int i = 0; i < 10; i++) begin
            rv = 4'($urandom);
            applyStimulus(rv, (i % 4 == 3) ? 255 : int'($urandom_range(1, 40)), ones);
        end

`ifdef STOCH_ENC_SEED_EN
        // Equal seeds give identical streams.
        seed_in = 8'h3C;
        applyStimulus(4'sd3, 30, ones);
        first_log = bit_log;
        applyStimulus(4'sd3, 30, ones);
        seed_in = 8'h00;
        checkOutput("seed_len", 32'(bit_log.size()), 32'(first_log.size()));
        for (int i = 0; i < first_log.size() && i < bit_log.size(); i++) begin
            checkOutput("seed_bit", 32'(bit_log[i]), 32'(first_log[i]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
